servant_sleep_ctrl: RTL and testbench
=====================================

# servant_sleep_ctrl

Sleep/wake sequencer for the servant SoC's gated bus clock. It accepts the core's sleep request and waits for the Wishbone bus to go idle. It then drops the clock enable that gates the CPU/bus clock. On a masked interrupt it re-enables the clock, waits a settle delay, and signals wakeup. It runs entirely on the ungated main clock, sits beside the servant top level, and drives the enable of an external latch-based clock gate.

## Interface
- `N_IRQ`, default 1: number of wake-source lines.
- `WAKE_DELAY`, default 4: cycles with the clock re-enabled before `o_wakeup` pulses; legal range 1..255.
- `CNT_W`, default 32: width of the sleep-cycle counter.
- `i_clk`, input, 1: main (ungated) clock.
- `i_rst_n`, input, 1: reset, synchronous, active-low.
- `i_sleep_req`, input, 1: level sleep request from the core (WFI); produced in the gated domain, so it holds its value while the clock is gated.
- `i_wb_cyc`, input, 1: bus cycle outstanding; high means not idle.
- `i_irq`, input, `N_IRQ`: level wake sources.
- `i_irq_mask`, input, `N_IRQ`: 1 enables the corresponding wake source; quasi-static.
- `o_clk_en`, output, 1: gated-clock enable (registered).
- `o_sleeping`, output, 1: high in the SLEEP state.
- `o_wakeup`, output, 1: one-cycle pulse on wake completion or on a refused sleep request.
- `o_wake_src`, output, `N_IRQ`: `i_irq & i_irq_mask` captured on the SLEEP->WAKE transition.
- `o_sleep_cycles`, output, `CNT_W`: saturating count of cycles spent in SLEEP.

## Operation
- `pend` = |(`i_irq` & `i_irq_mask`), evaluated combinationally.
- `armed` flag: cleared on reset and on every `o_wakeup` pulse; set when `i_sleep_req`=0 in RUN. A sleep request is honoured only while `armed`=1. This prevents re-entry on a request left stale from before the wake.
- States:
  - RUN: `o_clk_en`=1.
    - If `i_sleep_req` & `armed` & `pend`: stay in RUN, pulse `o_wakeup`, clear `armed` (refused sleep).
    - If `i_sleep_req` & `armed` & !`pend`: go to DRAIN.
  - DRAIN: `o_clk_en`=1.
    - If `pend`: go to RUN, pulse `o_wakeup` (abort). Abort has priority over idle.
    - Else if `i_wb_cyc`=0: go to SLEEP.
  - SLEEP: `o_clk_en`=0, `o_sleeping`=1, `o_sleep_cycles` += 1 per cycle, saturating at all-ones.
    - If `pend`: go to WAKE, latch `o_wake_src`.
  - WAKE: `o_clk_en`=1, delay counter runs from 0.
    - At count `WAKE_DELAY`-1: pulse `o_wakeup` and go to RUN.
    - `pend` dropping during WAKE does not stop the wake.
- Reset values: state RUN, `o_clk_en`=1, `o_sleeping`=0, `o_wakeup`=0, `o_wake_src`=0, `o_sleep_cycles`=0, `armed`=0, delay counter 0.
- Reset asserted in any state returns to RUN with the clock enabled on the next edge. The counter is cleared.
- `o_sleep_cycles` accumulates across sleeps and is cleared only by reset.

## Timing
- All outputs are registered and change only on `i_clk` rising edges. `o_clk_en` is glitch-free; the external gate latches it on the low phase.
- RUN->DRAIN: 1 cycle after `i_sleep_req` is sampled. DRAIN->SLEEP: 1 cycle after `i_wb_cyc`=0 is sampled.
- Sleep entry, minimum 2 cycles from request to `o_clk_en`=0:
  - edge 1 samples the request and enters DRAIN;
  - edge 2 samples idle, enters SLEEP and drives `o_clk_en`=0.
- Wake latency: `o_clk_en`=1 on the edge that samples `pend`. `o_wakeup` pulses `WAKE_DELAY` cycles later, with `o_clk_en`=1 throughout.
- An interrupt arriving in the same cycle the FSM samples `i_wb_cyc`=0 in DRAIN aborts; sleep is not entered.
- `o_sleeping` and `o_clk_en` are exact complements in every cycle.

## Structure
- Package `servant_sleep_pkg`:
  - `sleep_state_t` enum {RUN, DRAIN, SLEEP, WAKE}, binary encoding;
  - constant `WAKE_CNT_W` = 8.
- One sub-module, `servant_sat_counter`, parameterised by width, with clear and enable; it implements `o_sleep_cycles`.
- FSM, `armed` flag and wake-delay counter stay in the top module.

## Test plan
- Reset: hold `i_rst_n`=0 for 3 cycles -> `o_clk_en`=1 and all other outputs 0; sleep request at release is ignored until `i_sleep_req` has been low for 1 cycle.
- Basic sleep/wake, `WAKE_DELAY`=4, `i_irq_mask`=1:
  - request with bus idle -> `o_clk_en`=0 two cycles later;
  - hold 10 cycles, then `i_irq`=1 -> `o_clk_en`=1 the next edge, `o_wakeup` pulses 4 cycles later;
  - result: `o_sleep_cycles`=10, `o_wake_src`=1.
- Drain: request while `i_wb_cyc`=1 for 5 cycles -> stays in DRAIN with `o_clk_en`=1; SLEEP is entered 1 cycle after `i_wb_cyc` falls.
- Abort and refusal:
  - IRQ asserted during DRAIN -> back to RUN, one `o_wakeup` pulse, clock never gated;
  - request with a pending IRQ -> immediate `o_wakeup`, `o_clk_en` stays 1.
- Masking and re-arm:
  - `i_irq_mask`=0 -> IRQ does not wake, device stays asleep;
  - after a wake with `i_sleep_req` still 1 -> no re-entry until it drops for 1 cycle.
- Saturation and reset mid-sleep:
  - `CNT_W`=4, sleep for 20 cycles -> `o_sleep_cycles`=15;
  - reset asserted in SLEEP -> RUN, `o_clk_en`=1.

Source files
------------

// File: rtl/servant_sleep_pkg.sv
// Shared types for the servant sleep/wake sequencer.
package servant_sleep_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } sleep_state_t;

    localparam int WAKE_CNT_W = 8;

endpackage

// File: rtl/servant_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module servant_sat_counter
    import servant_sleep_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/servant_sleep_ctrl.sv
// Sleep/wake sequencer driving the enable of the servant gated bus clock.
module servant_sleep_ctrl
    import servant_sleep_pkg::*;
#(
    parameter int N_IRQ      = 1,
    parameter int WAKE_DELAY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sleep_req,
    input  logic             i_wb_cyc,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic [N_IRQ-1:0] i_irq_mask,
    output logic             o_clk_en,
    output logic             o_sleeping,
    output logic             o_wakeup,
    output logic [N_IRQ-1:0] o_wake_src,
    output logic [CNT_W-1:0] o_sleep_cycles
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_DELAY - 1);

    sleep_state_t          state_q, state_d;
    logic                  armed_q, armed_d;
    logic [WAKE_CNT_W-1:0] dcnt_q, dcnt_d;
    logic                  clk_en_q, clk_en_d;
    logic                  sleeping_q, sleeping_d;
    logic                  wakeup_q, wakeup_d;
    logic [N_IRQ-1:0]      wake_src_q, wake_src_d;
    logic                  pend;

    assign pend = |(i_irq & i_irq_mask);

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        dcnt_d     = '0;
        wakeup_d   = 1'b0;
        wake_src_d = wake_src_q;
        unique case (state_q)
            RUN: begin
                if (!i_sleep_req) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    if (pend) begin
                        wakeup_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Abort wins over bus idle sampled on the same edge
                if (pend) begin
                    state_d  = RUN;
                    wakeup_d = 1'b1;
                end else if (!i_wb_cyc) begin
                    state_d = SLEEP;
                end
            end
            SLEEP: begin
                if (pend) begin
                    state_d    = WAKE;
                    wake_src_d = i_irq & i_irq_mask;
                end
            end
            WAKE: begin
                if (dcnt_q == WAKE_LAST) begin
                    state_d  = RUN;
                    wakeup_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
        endcase
        if (wakeup_d) begin
            armed_d = 1'b0;
        end
        sleeping_d = (state_d == SLEEP);
        clk_en_d   = ~sleeping_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= RUN;
            armed_q    <= 1'b0;
            dcnt_q     <= '0;
            clk_en_q   <= 1'b1;
            sleeping_q <= 1'b0;
            wakeup_q   <= 1'b0;
            wake_src_q <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            dcnt_q     <= dcnt_d;
            clk_en_q   <= clk_en_d;
            sleeping_q <= sleeping_d;
            wakeup_q   <= wakeup_d;
            wake_src_q <= wake_src_d;
        end
    end

    servant_sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .i_clk (i_clk),
        .i_clr (~i_rst_n),
        .i_en  (state_q == SLEEP),
        .o_cnt (o_sleep_cycles)
    );

    assign o_clk_en   = clk_en_q;
    assign o_sleeping = sleeping_q;
    assign o_wakeup   = wakeup_q;
    assign o_wake_src = wake_src_q;

endmodule

// File: tb/tb_servant_sleep_ctrl.sv
// Directed self-checking bench for servant_sleep_ctrl.
module tb_servant_sleep_ctrl;

    localparam int N_IRQ = 2;
    localparam int WD    = 4;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req;
    logic             cyc;
    logic [N_IRQ-1:0] irq;
    logic [N_IRQ-1:0] mask;
    logic             clk_en;
    logic             sleeping;
    logic             wakeup;
    logic [N_IRQ-1:0] wake_src;
    logic [CW-1:0]    cycles;

    int n_assert = 0;
    int n_fail   = 0;

    servant_sleep_ctrl #(
        .N_IRQ      (N_IRQ),
        .WAKE_DELAY (WD),
        .CNT_W      (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_sleep_req    (req),
        .i_wb_cyc       (cyc),
        .i_irq          (irq),
        .i_irq_mask     (mask),
        .o_clk_en       (clk_en),
        .o_sleeping     (sleeping),
        .o_wakeup       (wakeup),
        .o_wake_src     (wake_src),
        .o_sleep_cycles (cycles)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_run(input string tag, input logic wk);
        chk({tag, "_clk_en"}, 32'(clk_en), 32'd1);
        chk({tag, "_sleeping"}, 32'(sleeping), 32'd0);
        chk({tag, "_wakeup"}, 32'(wakeup), 32'(wk));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b1;
        cyc   = 1'b0;
        irq   = '0;
        mask  = 2'b01;
        step(3);
        chk_run("rst", 1'b0);
        chk("rst_wake_src", 32'(wake_src), 32'd0);
        chk("rst_cycles", 32'(cycles), 32'd0);

        // stale request at release must be ignored
        rst_n = 1'b1;
        step(3);
        chk_run("stale", 1'b0);

        // basic sleep / wake
        req = 1'b0;
        step();
        req = 1'b1;
        step();
        chk_run("drain1", 1'b0);
        step();
        chk("sleep_clk_en", 32'(clk_en), 32'd0);
        chk("sleep_sleeping", 32'(sleeping), 32'd1);
        step(9);
        irq = 2'b01;
        step();
        chk_run("wake_edge", 1'b0);
        chk("wake_cycles", 32'(cycles), 32'd10);
        chk("wake_src", 32'(wake_src), 32'd1);
        irq = '0;
        step(3);
        chk_run("wake_d3", 1'b0);
        step();
        chk_run("wake_pulse", 1'b1);
        step();
        chk_run("wake_after", 1'b0);

        // no re-entry on a request held through the wake
        step(2);
        chk_run("rearm_hold", 1'b0);
        chk("rearm_cycles", 32'(cycles), 32'd10);

        // drain with a busy bus
        req = 1'b0;
        step();
        req = 1'b1;
        cyc = 1'b1;
        step();
        step(5);
        chk_run("drain_busy", 1'b0);
        cyc = 1'b0;
        step();
        chk("drain_sleep", 32'(sleeping), 32'd1);
        chk("drain_clk_en", 32'(clk_en), 32'd0);

        // masked source does not wake
        irq = 2'b10;
        step(3);
        chk("mask_sleeping", 32'(sleeping), 32'd1);
        chk("mask_clk_en", 32'(clk_en), 32'd0);

        // reset in SLEEP
        rst_n = 1'b0;
        step();
        chk_run("rst_sleep", 1'b0);
        chk("rst_sleep_cycles", 32'(cycles), 32'd0);
        rst_n = 1'b1;
        irq   = '0;

        // abort in DRAIN, same edge as bus idle
        req = 1'b0;
        step();
        req = 1'b1;
        step();
        irq = 2'b01;
        step();
        chk_run("abort", 1'b1);
        irq = '0;
        step();
        chk_run("abort_after", 1'b0);
        step(2);
        chk_run("abort_noreentry", 1'b0);

        // refusal with pending irq
        req = 1'b0;
        step();
        req = 1'b1;
        irq = 2'b01;
        step();
        chk_run("refuse", 1'b1);
        step();
        chk_run("refuse_after", 1'b0);
        irq = '0;
        step(2);
        chk_run("refuse_idle", 1'b0);

        // saturation over a long sleep, wake_src masked
        req = 1'b0;
        step();
        req = 1'b1;
        step(2);
        chk("sat_sleeping", 32'(sleeping), 32'd1);
        step(20);
        chk("sat_cycles", 32'(cycles), 32'd15);
        irq = 2'b11;
        step();
        chk_run("sat_wake", 1'b0);
        chk("sat_wake_src", 32'(wake_src), 32'd1);
        irq = '0;
        step(4);
        chk_run("sat_pulse", 1'b1);
        chk("sat_hold", 32'(cycles), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
